dvp_axil_regbank: RTL and testbench
===================================

// Module: dvp_axil_regbank
// PURPOSE
//  Parametrised AXI4-Lite control/status register bank for the DVP capture path.
//  Generalises the fixed 4x32 slave register set. Adds:
//  - N registers, each RW, RO (status-driven) or W1C (event-latched)
//  - byte strobes
//  - SLVERR for out-of-range addresses
//  - level interrupt from W1C bits
//  Sits between the PS GP port and the DVP capture/DDR writer control inputs.
// PARAMETERS
//  C_DATA_WIDTH  32          AXI data width; 32 or 64
//  C_ADDR_WIDTH  6           AXI address width in bytes; must cover C_NUM_REGS*C_DATA_WIDTH/8
//  C_NUM_REGS    8           number of registers, 1..64
//  C_RO_MASK     8'h00       bit i=1: reg i is read-only and reads status_in[i]
//  C_W1C_MASK    8'h00       bit i=1: reg i latches event_in[i] bits, cleared by writing 1 (RO wins over W1C)
//  C_RESET_VAL   {N{32'h0}}  reset value of RW regs, C_NUM_REGS*C_DATA_WIDTH bits
// PORTS
//  ACLK           in   1      clock
//  ARESETN        in   1      asynchronous active-low reset
//  S_AXI_AWADDR   in   AW     write address (byte)
//  S_AXI_AWPROT   in   3      ignored
//  S_AXI_AWVALID  in   1      / S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   DW     write data
//  S_AXI_WSTRB    in   DW/8   byte enables
//  S_AXI_WVALID   in   1      / S_AXI_WREADY out 1
//  S_AXI_BRESP    out  2      00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1      / S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   AW     read address
//  S_AXI_ARPROT   in   3      ignored
//  S_AXI_ARVALID  in   1      / S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  DW     read data
//  S_AXI_RRESP    out  2      as BRESP
//  S_AXI_RVALID   out  1      / S_AXI_RREADY in 1
//  reg_out        out  N*DW   flat register contents, reg i at [i*DW +: DW]
//  status_in      in   N*DW   RO register sources, sampled on read
//  event_in       in   N*DW   W1C set pulses, one-cycle, per bit
//  irq            out  1      OR of all W1C register bits, registered
// BEHAVIOUR
//  - Reset: all READY/VALID low; BRESP=RRESP=0; RDATA=0; irq=0; RW regs=C_RESET_VAL; W1C regs=0.
//  - Write channel: AW and W accepted independently, each held in a one-entry buffer.
//    AWREADY is high while the AW buffer is empty and BVALID=0; WREADY likewise.
//  - Commit happens the cycle after both buffers are full:
//    - Index = addr[AW-1:log2(DW/8)]; low address bits are ignored.
//    - RW reg: byte k updated iff WSTRB[k].
//    - W1C reg: bits with wdata=1 in strobed bytes cleared.
//    - RO reg: write ignored, BRESP=OKAY.
//    - Index >= C_NUM_REGS: no state change, BRESP=SLVERR.
//    - BVALID rises on the commit cycle and holds until BREADY. Buffers clear on the B handshake.
//    - Minimum write latency (AW&W together) to BVALID: 2 cycles.
//  - Read channel:
//    - ARREADY is high while RVALID=0 and no read is in flight.
//    - On the AR handshake, RDATA/RRESP are registered and RVALID is asserted the next cycle.
//    - RDATA is held until RREADY. Out-of-range reads return RDATA=0, RRESP=SLVERR.
//    - RO regs return status_in sampled at the AR handshake cycle.
//  - One outstanding read and one outstanding write; the read and write paths are fully concurrent.
//  - Same-cycle read and write commit to the same reg: the read returns the pre-commit value.
//  - W1C set/clear collision in one cycle: set wins (bit = 1).
//  - event_in is OR-ed in every cycle, independent of bus activity.
//  - irq is updated the cycle after any W1C bit changes.
//  - reg_out reflects committed state: RW/W1C regs from storage, RO slots read status_in.
//  - ARESETN assertion mid-transaction aborts it: buffers cleared, VALIDs dropped immediately (async).
//    There is no partial commit.
// TESTING
//  - Defaults (32b, 8 regs), reset: write 0x1..0x8 to 0x00..0x1C, read back -> identical, all RRESP=00.
//  - Strobes: reg1=0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> reads 0xAA22CC44.
//  - Ordering: AW three cycles before W, BREADY held low 5 cycles -> one commit; BVALID stays high, no 2nd AWREADY.
//  - Out of range: C_NUM_REGS=8, write/read 0x20 -> BRESP=RRESP=10, RDATA=0, reg_out unchanged.
//  - RO/W1C (C_RO_MASK=8'h04, C_W1C_MASK=8'h08):
//    - status_in reg2=0xCAFE0001 -> read 0x08 returns it.
//    - event_in reg3 bit0 -> irq=1. Write 0x1 to 0x0C while bit0 pulses the same cycle -> stays 1.
//    - Write 0x1 again -> irq=0.
//  - Reset: drop ARESETN with AW held and RVALID pending -> all VALIDs 0 in the same cycle, regs at C_RESET_VAL.

Source files
------------

// File: rtl/dvp_axil_regbank_if.sv
// AXI4-Lite slave bus bundle for the DVP control/status register bank.
interface dvp_axil_regbank_if #(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_ADDR_WIDTH = 6
);
  localparam int unsigned SW = C_DATA_WIDTH / 8;

  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [C_DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [SW-1:0]           S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [C_DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/dvp_axil_regbank.sv
// AXI4-Lite register bank for the DVP capture path: RW / RO / W1C registers,
// byte strobes, SLVERR on out-of-range indices and a level interrupt.
module dvp_axil_regbank #(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_ADDR_WIDTH = 6,
  parameter int unsigned C_NUM_REGS   = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK  = '0,
  parameter logic [C_NUM_REGS-1:0] C_W1C_MASK = '0,
  parameter logic [C_NUM_REGS*C_DATA_WIDTH-1:0] C_RESET_VAL = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  dvp_axil_regbank_if.slave                  s_axi,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] event_in,
  output logic                               irq
);

  localparam int unsigned DW  = C_DATA_WIDTH;
  localparam int unsigned AW  = C_ADDR_WIDTH;
  localparam int unsigned N   = C_NUM_REGS;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned LSB = $clog2(SW);
  localparam int unsigned IW  = AW - LSB;

  // Register roles; RO takes precedence over W1C.
  localparam logic [N-1:0] RO_M  = C_RO_MASK;
  localparam logic [N-1:0] W1C_M = C_W1C_MASK & ~C_RO_MASK;
  localparam logic [N-1:0] RW_M  = ~(RO_M | W1C_M);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel state
  logic          aw_full_q, aw_full_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic          w_full_q, w_full_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;

  // Read channel state
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  // Register storage
  logic [DW-1:0] regs_q [N];
  logic [DW-1:0] regs_d [N];
  logic          irq_q, irq_d;

  logic [IW-1:0] wr_idx_c, rd_idx_c;
  logic          wr_oor_c, rd_oor_c, commit_c, ar_hs_c;
  logic [DW-1:0] bmask_c, rd_data_c;
  logic          unused_c;

  assign wr_idx_c = awaddr_q[AW-1:LSB];
  assign rd_idx_c = s_axi.S_AXI_ARADDR[AW-1:LSB];
  assign wr_oor_c = 32'(wr_idx_c) >= N;
  assign rd_oor_c = 32'(rd_idx_c) >= N;
  assign commit_c = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_hs_c  = arready_q & s_axi.S_AXI_ARVALID;

  assign unused_c = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr_q[LSB-1:0],
                      s_axi.S_AXI_ARADDR[LSB-1:0], status_in, event_in};

  // Write-channel buffers, commit response and ready generation
  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (awready_q && s_axi.S_AXI_AWVALID) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axi.S_AXI_AWADDR;
    end
    if (wready_q && s_axi.S_AXI_WVALID) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end
    if (commit_c) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_oor_c ? RESP_SLVERR : RESP_OKAY;
    end
    if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;
  end

  // Strobe bytes expanded to a bit mask
  always_comb begin
    bmask_c = '0;
    for (int k = 0; k < int'(SW); k++) begin
      bmask_c[k*8 +: 8] = {8{wstrb_q[k]}};
    end
  end

  // Register next state: RW byte merge, W1C clear with event set winning
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      regs_d[i] = regs_q[i];
      if (RO_M[i]) begin
        regs_d[i] = '0;
      end else if (W1C_M[i]) begin
        if (commit_c && !wr_oor_c && wr_idx_c == IW'(i)) begin
          regs_d[i] = regs_q[i] & ~(wdata_q & bmask_c);
        end
        regs_d[i] = regs_d[i] | event_in[i*DW +: DW];
      end else if (commit_c && !wr_oor_c && wr_idx_c == IW'(i)) begin
        regs_d[i] = (regs_q[i] & ~bmask_c) | (wdata_q & bmask_c);
      end
    end
  end

  // Interrupt follows the committed W1C contents one cycle later
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (W1C_M[i]) irq_d = irq_d | (|regs_q[i]);
    end
  end

  // Read mux over pre-commit storage; RO slots sample status_in
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!rd_oor_c && rd_idx_c == IW'(i)) begin
        rd_data_c = RO_M[i] ? status_in[i*DW +: DW] : regs_q[i];
      end
    end
  end

  // Read channel: capture on AR handshake, hold until RREADY
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_c;
      rresp_d  = rd_oor_c ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    arready_d = ~rvalid_d;
  end

  // Flat register view: storage for RW/W1C, live status for RO
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(N); i++) begin
      reg_out[i*DW +: DW] = RO_M[i] ? status_in[i*DW +: DW] : regs_q[i];
    end
  end

  // State registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      irq_q     <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        regs_q[i] <= RW_M[i] ? C_RESET_VAL[i*DW +: DW] : '0;
      end
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      irq_q     <= irq_d;
      for (int i = 0; i < int'(N); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign irq                 = irq_q;

endmodule

// File: tb/tb_dvp_axil_regbank.sv
// Directed bench: dut_a uses default parameters, dut_b has RO reg2, W1C reg3
// and non-zero reset values. One shared master drives whichever DUT sel picks.
module tb_dvp_axil_regbank;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  localparam logic [255:0] RST_B = {32'h0, 32'h0, 32'h0, 32'h0,
                                    32'hFFFFFFFF, 32'h0, 32'h0, 32'h12345678};

  dvp_axil_regbank_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(6)) bus_a ();
  dvp_axil_regbank_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(6)) bus_b ();

  logic [255:0] reg_out_a, reg_out_b, status_a, status_b, event_a, event_b;
  logic         irq_a, irq_b;

  dvp_axil_regbank dut_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus_a.slave),
    .reg_out(reg_out_a), .status_in(status_a), .event_in(event_a), .irq(irq_a)
  );

  dvp_axil_regbank #(
    .C_NUM_REGS(8), .C_RO_MASK(8'h04), .C_W1C_MASK(8'h08), .C_RESET_VAL(RST_B)
  ) dut_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus_b.slave),
    .reg_out(reg_out_b), .status_in(status_b), .event_in(event_b), .irq(irq_b)
  );

  // Shared master signals
  logic        sel = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  assign bus_a.S_AXI_AWADDR = awaddr;  assign bus_b.S_AXI_AWADDR = awaddr;
  assign bus_a.S_AXI_AWPROT = 3'b0;    assign bus_b.S_AXI_AWPROT = 3'b0;
  assign bus_a.S_AXI_WDATA  = wdata;   assign bus_b.S_AXI_WDATA  = wdata;
  assign bus_a.S_AXI_WSTRB  = wstrb;   assign bus_b.S_AXI_WSTRB  = wstrb;
  assign bus_a.S_AXI_ARADDR = araddr;  assign bus_b.S_AXI_ARADDR = araddr;
  assign bus_a.S_AXI_ARPROT = 3'b0;    assign bus_b.S_AXI_ARPROT = 3'b0;
  assign bus_a.S_AXI_AWVALID = awvalid & ~sel;  assign bus_b.S_AXI_AWVALID = awvalid & sel;
  assign bus_a.S_AXI_WVALID  = wvalid & ~sel;   assign bus_b.S_AXI_WVALID  = wvalid & sel;
  assign bus_a.S_AXI_BREADY  = bready & ~sel;   assign bus_b.S_AXI_BREADY  = bready & sel;
  assign bus_a.S_AXI_ARVALID = arvalid & ~sel;  assign bus_b.S_AXI_ARVALID = arvalid & sel;
  assign bus_a.S_AXI_RREADY  = rready & ~sel;   assign bus_b.S_AXI_RREADY  = rready & sel;

  assign awready = sel ? bus_b.S_AXI_AWREADY : bus_a.S_AXI_AWREADY;
  assign wready  = sel ? bus_b.S_AXI_WREADY  : bus_a.S_AXI_WREADY;
  assign bvalid  = sel ? bus_b.S_AXI_BVALID  : bus_a.S_AXI_BVALID;
  assign bresp   = sel ? bus_b.S_AXI_BRESP   : bus_a.S_AXI_BRESP;
  assign arready = sel ? bus_b.S_AXI_ARREADY : bus_a.S_AXI_ARREADY;
  assign rvalid  = sel ? bus_b.S_AXI_RVALID  : bus_a.S_AXI_RVALID;
  assign rdata   = sel ? bus_b.S_AXI_RDATA   : bus_a.S_AXI_RDATA;
  assign rresp   = sel ? bus_b.S_AXI_RRESP   : bus_a.S_AXI_RRESP;

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Full write: AW and W presented together, then B collected.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    bit aw_done = 0, w_done = 0, got = 0;
    int n = 0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    resp = 2'bxx;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge ACLK);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      tick();
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!got && n < 20) begin
      @(negedge ACLK);
      if (bvalid) begin resp = bresp; got = 1; end
      n++;
    end
    tick();
    bready = 1'b0;
    ok = aw_done && w_done && got;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output bit ok);
    bit ar_done = 0, got = 0;
    int n = 0;
    araddr = a; arvalid = 1'b1;
    d = 'x; resp = 2'bxx;
    while (!ar_done && n < 20) begin
      @(negedge ACLK);
      if (arready) ar_done = 1;
      tick();
      n++;
    end
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (ar_done && !got && n < 20) begin
      @(negedge ACLK);
      if (rvalid) begin d = rdata; resp = rresp; got = 1; end
      n++;
    end
    tick();
    rready = 1'b0;
    ok = ar_done && got;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, irq_b} !== 6'b0 || rdata !== 32'h0 ||
        bresp !== 2'b00 || rresp !== 2'b00) begin
      fails++;
      $display("FAIL reset_outputs: rdy/vld=%b rdata=%h bresp=%b rresp=%b, required all 0",
               {awready, wready, bvalid, arready, rvalid, irq_b}, rdata, bresp, rresp);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ready: aw/w/ar ready=%b, required 111", {awready, wready, arready});
    end
    tests++;
    if (reg_out_a !== 256'h0) begin
      fails++;
      $display("FAIL reset_regs_a: reg_out=%h, required 0", reg_out_a);
    end
    tests++;
    if (reg_out_b !== {128'h0, 32'h0, 32'h0, 32'h0, 32'h12345678}) begin
      fails++;
      $display("FAIL reset_regs_b: reg_out=%h, required reg0=12345678 rest 0", reg_out_b);
    end
  endtask

  task automatic test_rw_readback();
    logic [1:0] resp; logic [31:0] d; bit ok;
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      axi_write(6'(4 * i), 32'(i + 1), 4'hF, resp, ok);
      tests++;
      if (!ok || resp !== 2'b00) begin
        fails++;
        $display("FAIL rw_write reg%0d: ok=%0d bresp=%b, required ok=1 bresp=00", i, ok, resp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      axi_read(6'(4 * i), d, resp, ok);
      tests++;
      if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin
        fails++;
        $display("FAIL rw_read reg%0d: ok=%0d rdata=%h rresp=%b, required %h/00",
                 i, ok, d, resp, 32'(i + 1));
      end
    end
    tests++;
    if (reg_out_a !== {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1}) begin
      fails++;
      $display("FAIL rw_reg_out: got %h, required 8..1", reg_out_a);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp; logic [31:0] d; bit ok;
    sel = 1'b0;
    axi_write(6'h04, 32'hAABBCCDD, 4'hF, resp, ok);
    axi_write(6'h04, 32'h11223344, 4'b0101, resp, ok);
    axi_read(6'h04, d, resp, ok);
    tests++;
    if (!ok || d !== 32'hAA22CC44 || resp !== 2'b00) begin
      fails++;
      $display("FAIL strobe_merge: rdata=%h rresp=%b, required AA22CC44/00", d, resp);
    end
  endtask

  task automatic test_ordering();
    logic [1:0] resp; logic [31:0] d; bit ok;
    sel = 1'b0;
    bready = 1'b0;
    awaddr = 6'h10; awvalid = 1'b1;
    @(negedge ACLK);
    tests++;
    if (awready !== 1'b1) begin
      fails++;
      $display("FAIL order_awready: got %b, required 1", awready);
    end
    tick();
    awvalid = 1'b0;
    tick();
    tick();
    @(negedge ACLK);
    tests++;
    if (bvalid !== 1'b0) begin
      fails++;
      $display("FAIL order_no_early_b: bvalid=%b before W, required 0", bvalid);
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    awaddr = 6'h14; awvalid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      tests++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        fails++;
        $display("FAIL order_hold cyc%0d: bvalid=%b awready=%b, required 1/0", k, bvalid, awready);
      end
      tick();
    end
    awvalid = 1'b0;
    bready = 1'b1;
    @(negedge ACLK);
    tests++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      fails++;
      $display("FAIL order_bresp: bvalid=%b bresp=%b, required 1/00", bvalid, bresp);
    end
    tick();
    bready = 1'b0;
    @(negedge ACLK);
    tests++;
    if (bvalid !== 1'b0) begin
      fails++;
      $display("FAIL order_b_drop: bvalid=%b after handshake, required 0", bvalid);
    end
    tick();
    axi_read(6'h10, d, resp, ok);
    tests++;
    if (!ok || d !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL order_commit: reg4=%h, required DEADBEEF", d);
    end
    axi_read(6'h14, d, resp, ok);
    tests++;
    if (!ok || d !== 32'h6) begin
      fails++;
      $display("FAIL order_single_commit: reg5=%h, required 00000006", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] d; bit ok;
    sel = 1'b0;
    axi_write(6'h20, 32'hFFFFFFFF, 4'hF, resp, ok);
    tests++;
    if (!ok || resp !== 2'b10) begin
      fails++;
      $display("FAIL oor_bresp: ok=%0d bresp=%b, required 10", ok, resp);
    end
    axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, resp, ok);
    tests++;
    if (!ok || resp !== 2'b10) begin
      fails++;
      $display("FAIL oor_bresp_top: ok=%0d bresp=%b, required 10", ok, resp);
    end
    axi_read(6'h20, d, resp, ok);
    tests++;
    if (!ok || d !== 32'h0 || resp !== 2'b10) begin
      fails++;
      $display("FAIL oor_read: rdata=%h rresp=%b, required 00000000/10", d, resp);
    end
    tests++;
    if (reg_out_a !== {32'h8, 32'h7, 32'h6, 32'hDEADBEEF, 32'h4, 32'h3, 32'hAA22CC44, 32'h1}) begin
      fails++;
      $display("FAIL oor_reg_out: got %h, required unchanged contents", reg_out_a);
    end
  endtask

  task automatic test_ro_w1c();
    logic [1:0] resp; logic [31:0] d; bit ok;
    sel = 1'b1;
    status_b[2*32 +: 32] = 32'hCAFE0001;
    axi_read(6'h08, d, resp, ok);
    tests++;
    if (!ok || d !== 32'hCAFE0001 || resp !== 2'b00) begin
      fails++;
      $display("FAIL ro_read: rdata=%h rresp=%b, required CAFE0001/00", d, resp);
    end
    axi_write(6'h08, 32'hFFFFFFFF, 4'hF, resp, ok);
    tests++;
    if (!ok || resp !== 2'b00 || reg_out_b[2*32 +: 32] !== 32'hCAFE0001) begin
      fails++;
      $display("FAIL ro_write: bresp=%b slot=%h, required 00/CAFE0001", resp, reg_out_b[2*32 +: 32]);
    end
    // one-cycle event on reg3 bit0
    event_b[96] = 1'b1;
    tick();
    event_b[96] = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (irq_b !== 1'b1 || reg_out_b[3*32 +: 32] !== 32'h1) begin
      fails++;
      $display("FAIL w1c_set: irq=%b reg3=%h, required 1/00000001", irq_b, reg_out_b[3*32 +: 32]);
    end
    // clear collides with a new event pulse on the commit cycle
    awaddr = 6'h0C; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    event_b[96] = 1'b1;
    tick();
    event_b[96] = 1'b0;
    bready = 1'b1;
    @(negedge ACLK);
    tests++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      fails++;
      $display("FAIL w1c_collide_b: bvalid=%b bresp=%b, required 1/00", bvalid, bresp);
    end
    tick();
    bready = 1'b0;
    tick(); tick();
    tests++;
    if (irq_b !== 1'b1 || reg_out_b[3*32 +: 32] !== 32'h1) begin
      fails++;
      $display("FAIL w1c_collide: irq=%b reg3=%h, required 1/00000001", irq_b, reg_out_b[3*32 +: 32]);
    end
    axi_write(6'h0C, 32'h1, 4'hF, resp, ok);
    tick(); tick();
    tests++;
    if (irq_b !== 1'b0 || reg_out_b[3*32 +: 32] !== 32'h0) begin
      fails++;
      $display("FAIL w1c_clear: irq=%b reg3=%h, required 0/00000000", irq_b, reg_out_b[3*32 +: 32]);
    end
    // strobes gate the clear
    event_b[3*32 +: 32] = 32'h00000300;
    tick();
    event_b[3*32 +: 32] = 32'h0;
    axi_write(6'h0C, 32'h00000100, 4'b0001, resp, ok);
    axi_read(6'h0C, d, resp, ok);
    tests++;
    if (!ok || d !== 32'h00000300) begin
      fails++;
      $display("FAIL w1c_unstrobed: reg3=%h, required 00000300", d);
    end
    axi_write(6'h0C, 32'h00000100, 4'b0010, resp, ok);
    axi_read(6'h0C, d, resp, ok);
    tests++;
    if (!ok || d !== 32'h00000200) begin
      fails++;
      $display("FAIL w1c_strobed: reg3=%h, required 00000200", d);
    end
    axi_write(6'h0C, 32'hFFFFFFFF, 4'hF, resp, ok);
    tick(); tick();
    tests++;
    if (irq_b !== 1'b0) begin
      fails++;
      $display("FAIL w1c_irq_low: irq=%b, required 0", irq_b);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] resp; logic [31:0] d; bit ok;
    sel = 1'b0;
    araddr = 6'h00; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    awaddr = 6'h04; awvalid = 1'b1;
    tick();
    @(negedge ACLK);
    tests++;
    if (rvalid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pending: rvalid=%b, required 1", rvalid);
    end
    #1;
    ARESETN = 1'b0;
    #1;
    tests++;
    if ({bus_a.S_AXI_AWREADY, bus_a.S_AXI_WREADY, bus_a.S_AXI_BVALID, bus_a.S_AXI_ARREADY,
         bus_a.S_AXI_RVALID, bus_b.S_AXI_BVALID, bus_b.S_AXI_RVALID, irq_b} !== 8'b0) begin
      fails++;
      $display("FAIL midrst_async: ready/valid/irq=%b, required all 0",
               {bus_a.S_AXI_AWREADY, bus_a.S_AXI_WREADY, bus_a.S_AXI_BVALID, bus_a.S_AXI_ARREADY,
                bus_a.S_AXI_RVALID, bus_b.S_AXI_BVALID, bus_b.S_AXI_RVALID, irq_b});
    end
    tests++;
    if (reg_out_a !== 256'h0 ||
        reg_out_b !== {128'h0, 32'h0, 32'hCAFE0001, 32'h0, 32'h12345678}) begin
      fails++;
      $display("FAIL midrst_regs: a=%h b=%h, required reset contents", reg_out_a, reg_out_b);
    end
    awvalid = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    @(negedge ACLK);
    tests++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_no_stale_aw: bvalid=%b awready=%b, required 0/1", bvalid, awready);
    end
    // complete the lone W with a fresh AW so the bench leaves the DUT idle
    tick();
    axi_write(6'h00, 32'h0, 4'h0, resp, ok);
    axi_read(6'h04, d, resp, ok);
    tests++;
    if (!ok || d !== 32'h0) begin
      fails++;
      $display("FAIL midrst_reg1: rdata=%h, required 00000000", d);
    end
  endtask

  initial begin
    status_a = '0; status_b = '0; event_a = '0; event_b = '0;
    test_reset();
    test_rw_readback();
    test_strobes();
    test_ordering();
    test_out_of_range();
    test_ro_w1c();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
